// File: rtl/mips_mem_pkg.sv
// Shared definitions for the shared-memory port arbiter.
//   state_t      : arbiter FSM state encoding
//   MEM_LAT_DEF  : default memory read latency (cycles)
//   STARVE_MAX_DEF : default number of consecutive DM grants tolerated while IF waits
//   cnt_w()      : width of a counter able to hold values 0..n-1 (minimum 1 bit)
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between the fetch stage (IF)
// and the data-memory stage (DM). One access at a time: arbitrate in IDLE,
// strobe the memory for one cycle in ISSUE, wait MEM_LAT cycles in WAIT
// (reads only), then pulse the winner's ready for one cycle in RESP.
//
// Handshake: each requester raises *_req as a level and holds it, together
// with its address/data, until its *_ready pulses for one cycle; *_rdata is
// valid during that pulse and held afterwards. Only one ready pulses at a time.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   if_req/if_addr                : fetch request (always a read)
//   if_rdata/if_ready             : fetch result and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request
//   dm_rdata/dm_ready             : data result and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata : registered memory command
//   mem_rdata                     : memory read data, MEM_LAT cycles after mem_en
//   stall_if/stall_mem            : requester pending and not completing this cycle
//   busy                          : FSM not idle
//   dbg_state                     : current FSM state
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam int LW = cnt_w(MEM_LAT);
  localparam int SW = cnt_w(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        state_q;
  logic          gnt_dm_q;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [LW-1:0] lat_cnt_q;
  logic [SW-1:0] starve_q;
  logic          if_ready_q, dm_ready_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;

  // Arbitration decision, only consumed in IDLE.
  logic          force_if;
  logic          gnt_dm_d;
  logic [SW-1:0] starve_d;

  always_comb begin
    force_if = if_req && (starve_q == STARVE_LIM);
    gnt_dm_d = dm_req && !force_if;
    starve_d = '0;
    // Count DM wins only while IF is actually waiting; saturate at the limit.
    if (if_req && gnt_dm_d) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_dm_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      mem_en_q   <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          starve_q <= starve_d;
          if (if_req || dm_req) begin
            gnt_dm_q   <= gnt_dm_d;
            mem_en_q   <= 1'b1;
            mem_we_q   <= gnt_dm_d && dm_we;
            mem_addr_q <= gnt_dm_d ? dm_addr : if_addr;
            if (gnt_dm_d) begin
              mem_wdata_q <= dm_wdata;
            end
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_we_q <= 1'b0;
          if (mem_we_q) begin
            // Writes only ever come from DM and need no read wait.
            dm_ready_q <= 1'b1;
            state_q    <= ST_RESP;
          end else begin
            lat_cnt_q <= LAT_INIT;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt_q == '0) begin
            if (gnt_dm_q) begin
              dm_rdata_q <= mem_rdata;
              dm_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= mem_rdata;
              if_ready_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - LW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = dm_req & ~dm_ready_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_a, rst_b, mem_init;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT A: MEM_LAT=1 ----------------
  logic        a_if_req, a_dm_req, a_dm_we;
  logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_if_ready, a_dm_ready, a_mem_en, a_mem_we;
  logic        a_stall_if, a_stall_mem, a_busy;
  logic [1:0]  a_state;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst_a),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_ready(a_dm_ready),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata),
    .stall_if(a_stall_if), .stall_mem(a_stall_mem), .busy(a_busy), .dbg_state(a_state)
  );

  // ---------------- DUT B: MEM_LAT=3 ----------------
  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_ready, b_dm_ready, b_mem_en, b_mem_we;
  logic        b_stall_if, b_stall_mem, b_busy;
  logic [1:0]  b_state;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst_b),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata),
    .stall_if(b_stall_if), .stall_mem(b_stall_mem), .busy(b_busy), .dbg_state(b_state)
  );

  // ---------------- memory models (MEM[i]=i after init) ----------------
  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  logic [31:0] a_p0, b_p0, b_p1, b_p2;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= 32'(i);
    end else if (a_mem_en) begin
      if (a_mem_we) mem_a[a_mem_addr[5:0]] <= a_mem_wdata;
      a_p0 <= mem_a[a_mem_addr[5:0]];
    end
  end
  assign a_mem_rdata = a_p0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= 32'(i);
    end else begin
      if (b_mem_en) begin
        if (b_mem_we) mem_b[b_mem_addr[5:0]] <= b_mem_wdata;
        b_p0 <= mem_b[b_mem_addr[5:0]];
      end
      b_p1 <= b_p0;
      b_p2 <= b_p1;
    end
  end
  assign b_mem_rdata = b_p2;

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard for grant order ----------------
  logic [31:0] exp_q[$];
  logic [31:0] grants[$];
  logic        both_ready_seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; mem_init = 1'b1;
    a_if_req = 0; a_if_addr = 0; a_dm_req = 0; a_dm_we = 0; a_dm_addr = 0; a_dm_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0;
    both_ready_seen = 1'b0;
    tick(); tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0; mem_init = 1'b0;

    // Reset state
    chk("rst_busy", a_busy, 0);
    chk("rst_mem_en", a_mem_en, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_if_ready", a_if_ready, 0);
    chk("rst_dm_ready", a_dm_ready, 0);
    chk("rst_if_rdata", a_if_rdata, 0);
    chk("rst_dm_rdata", a_dm_rdata, 0);
    chk("rst_state", a_state, 0);

    // 1: IF only, addr 8
    a_if_req = 1; a_if_addr = 32'd8; #1;
    chk("t1_stall_T", a_stall_if, 1);
    tick();
    chk("t1_mem_en_T1", a_mem_en, 1);
    chk("t1_mem_addr", a_mem_addr, 32'd8);
    chk("t1_mem_we", a_mem_we, 0);
    chk("t1_busy", a_busy, 1);
    chk("t1_stall_T1", a_stall_if, 1);
    tick();
    chk("t1_mem_en_T2", a_mem_en, 0);
    chk("t1_ready_T2", a_if_ready, 0);
    chk("t1_stall_T2", a_stall_if, 1);
    tick();
    chk("t1_ready_T3", a_if_ready, 1);
    chk("t1_rdata", a_if_rdata, 32'd8);
    chk("t1_stall_T3", a_stall_if, 0);
    a_if_req = 0;
    tick();
    chk("t1_ready_pulse", a_if_ready, 0);
    chk("t1_idle", a_busy, 0);
    chk("t1_rdata_held", a_if_rdata, 32'd8);

    // 2: DM write addr 5 <- 99, then read back
    a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'd5; a_dm_wdata = 32'd99; #1;
    chk("t2_stall_mem_T", a_stall_mem, 1);
    tick();
    chk("t2_mem_en", a_mem_en, 1);
    chk("t2_mem_we", a_mem_we, 1);
    chk("t2_mem_addr", a_mem_addr, 32'd5);
    chk("t2_mem_wdata", a_mem_wdata, 32'd99);
    tick();
    chk("t2_wr_ready_T2", a_dm_ready, 1);
    chk("t2_stall_mem_T2", a_stall_mem, 0);
    chk("t2_if_ready_quiet", a_if_ready, 0);
    a_dm_req = 0;
    tick();
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'd5; a_dm_wdata = 32'd0;
    tick();
    chk("t2_rd_mem_we", a_mem_we, 0);
    tick();
    chk("t2_rd_not_yet", a_dm_ready, 0);
    tick();
    chk("t2_rd_ready", a_dm_ready, 1);
    chk("t2_rd_data", a_dm_rdata, 32'd99);
    chk("t2_if_rdata_held", a_if_rdata, 32'd8);
    a_dm_req = 0;
    tick();

    // 3: both request, DM read 3 wins, then IF read 4
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'd3;
    a_if_req = 1; a_if_addr = 32'd4;
    tick();
    chk("t3_first_addr", a_mem_addr, 32'd3);
    tick();
    tick();
    chk("t3_dm_ready", a_dm_ready, 1);
    chk("t3_dm_rdata", a_dm_rdata, 32'd3);
    chk("t3_if_not_ready", a_if_ready, 0);
    chk("t3_stall_if", a_stall_if, 1);
    a_dm_req = 0;
    tick();
    tick();
    chk("t3_second_en", a_mem_en, 1);
    chk("t3_second_addr", a_mem_addr, 32'd4);
    tick();
    tick();
    chk("t3_if_ready", a_if_ready, 1);
    chk("t3_if_rdata", a_if_rdata, 32'd4);
    chk("t3_dm_rdata_held", a_dm_rdata, 32'd3);
    a_if_req = 0;
    tick();

    // 4: starvation limit -- 4 DM grants, IF on the 5th, counter cleared so DM wins 6th
    exp_q = '{32'd10, 32'd10, 32'd10, 32'd10, 32'd20, 32'd10};
    grants.delete();
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'd10;
    a_if_req = 1; a_if_addr = 32'd20;
    for (int cyc = 0; cyc < 60 && grants.size() < 6; cyc++) begin
      tick();
      if (a_mem_en) grants.push_back(a_mem_addr);
      if (a_if_ready && a_dm_ready) both_ready_seen = 1'b1;
    end
    a_dm_req = 0; a_if_req = 0;
    for (int cyc = 0; cyc < 10 && a_busy; cyc++) begin
      tick();
      if (a_if_ready && a_dm_ready) both_ready_seen = 1'b1;
    end
    chk("t4_grant_count", grants.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < grants.size()) chk($sformatf("t4_grant%0d", i), grants[i], exp_q[i]);
    end
    chk("t4_both_ready", both_ready_seen, 0);
    chk("t4_if_rdata", a_if_rdata, 32'd20);
    chk("t4_dm_rdata", a_dm_rdata, 32'd10);
    chk("t4_idle", a_busy, 0);
    tick();

    // 5: MEM_LAT=3, IF read addr 7
    b_if_req = 1; b_if_addr = 32'd7;
    tick();
    chk("t5_mem_en", b_mem_en, 1);
    chk("t5_mem_addr", b_mem_addr, 32'd7);
    tick();
    chk("t5_wait_T2", b_state, 2);
    tick();
    tick();
    chk("t5_wait_T4", b_state, 2);
    chk("t5_not_ready_T4", b_if_ready, 0);
    tick();
    chk("t5_ready_T5", b_if_ready, 1);
    chk("t5_rdata", b_if_rdata, 32'd7);
    b_if_req = 0;
    tick();
    chk("t5_idle", b_busy, 0);

    // 6: reset during WAIT, then a normal access
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'd6;
    tick();
    tick();
    chk("t6_in_wait", a_state, 2);
    rst_a = 1; a_dm_req = 0;
    tick();
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_mem_en", a_mem_en, 0);
    chk("t6_rst_dm_ready", a_dm_ready, 0);
    chk("t6_rst_dm_rdata", a_dm_rdata, 0);
    chk("t6_rst_if_rdata", a_if_rdata, 0);
    rst_a = 0;
    tick();
    chk("t6_no_stray_ready", a_dm_ready, 0);
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'd6;
    tick();
    chk("t6_mem_addr", a_mem_addr, 32'd6);
    tick();
    tick();
    chk("t6_ready", a_dm_ready, 1);
    chk("t6_rdata", a_dm_rdata, 32'd6);
    a_dm_req = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
